// File: rtl/cache_tag_nway_pkg.sv
// cache_tag_nway_pkg: shared cache-op encodings, FSM states and size defaults for the tag store
package cache_tag_nway_pkg;
  localparam int WAYS_DEF = 2;
  localparam int SETS_DEF = 64;
  localparam int OFFSET_W_DEF = 6;
  localparam logic [2:0] COP_INDEX_INV = 3'd0;
  localparam logic [2:0] COP_INDEX_STORE_TAG = 3'd1;
  localparam logic [2:0] COP_HIT_INV = 3'd2;
  localparam logic [2:0] COP_INDEX_WB_INV = 3'd3;
  localparam logic [2:0] COP_HIT_WB_INV = 3'd4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB = 2'd1,
    ST_REFILL = 2'd2,
    ST_COP_WB = 2'd3
  } state_e;
endpackage

// File: rtl/cache_tag_nway_plru_tree.sv
// plru_tree: pseudo-LRU victim pick and update for one set (1 bit for 2 ways, 3-bit tree for 4)
//   i_bits   current PLRU bits of the set
//   i_way    way being accessed (hit or fill)
//   o_victim way the bits point at
//   o_next   bits after accessing i_way
module plru_tree
  import cache_tag_nway_pkg::*;
#(
  parameter int WAYS = WAYS_DEF,
  localparam int WAY_W = $clog2(WAYS),
  localparam int PW = WAYS - 1
) (
  input  logic [PW-1:0]    i_bits,
  input  logic [WAY_W-1:0] i_way,
  output logic [WAY_W-1:0] o_victim,
  output logic [PW-1:0]    o_next
);
  generate
    if (WAYS == 2) begin : g_two
      assign o_victim = i_bits;
      assign o_next = ~i_way;
    end else begin : g_four
      // bit0 picks the half, bit1 the left pair, bit2 the right pair
      assign o_victim = i_bits[0] ? {1'b1, i_bits[2]} : {1'b0, i_bits[1]};
      assign o_next = i_way[1] ? {~i_way[0], i_bits[1], 1'b0} : {i_bits[2], ~i_way[0], 1'b1};
    end
  endgenerate
endmodule

// File: rtl/cache_tag_nway.sv
// cache_tag_nway: N-way tag store with miss/write-back/refill sequencing and cache maintenance ops
//   clk, rst               clock, synchronous active-high reset
//   flush, cached, req_*   lookup request and qualifiers
//   hit, miss, stallreq    lookup result and pipeline stall
//   victim                 way being filled or written back
//   wb_*, rf_*             write-back and refill handshakes
//   cop_*                  cache op request and one-cycle completion pulse
module cache_tag_nway
  import cache_tag_nway_pkg::*;
#(
  parameter int WAYS = WAYS_DEF,
  parameter int SETS = SETS_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS),
  localparam int TAG_W = 32 - IDX_W - OFFSET_W,
  localparam int PW = WAYS - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cached,
  input  logic             req_en,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  output logic [WAYS-1:0]  hit,
  output logic             miss,
  output logic             stallreq,
  output logic [WAY_W-1:0] victim,
  output logic             wb_req,
  output logic [31:0]      wb_addr,
  input  logic             wb_ack,
  output logic             rf_req,
  output logic [31:0]      rf_addr,
  input  logic             rf_ack,
  input  logic             cop_valid,
  input  logic [2:0]       cop_type,
  output logic             cop_done
);
  state_e r_state;
  logic [WAYS-1:0] r_valid [SETS];
  logic [WAYS-1:0] r_dirty [SETS];
  logic [TAG_W-1:0] r_tag [SETS][WAYS];
  logic [PW-1:0] r_plru [SETS];
  logic [WAY_W-1:0] r_victim;
  logic [TAG_W-1:0] r_tag_l;
  logic [IDX_W-1:0] r_idx;
  logic r_we;
  logic [IDX_W-1:0] w_idx, w_set;
  logic [TAG_W-1:0] w_tag;
  logic [WAYS-1:0] w_match;
  logic [WAY_W-1:0] w_hit_way, w_free_way, w_plru_victim, w_victim, w_cop_way;
  logic [PW-1:0] w_plru_next;
  logic w_free, w_idle, w_refill, w_lookup, w_cop_idx_op, w_cop_hit_op, w_cop_sel, w_cop_wb, w_cop_go;
  logic w_unused;
  assign w_idx = req_addr[OFFSET_W +: IDX_W];
  assign w_tag = req_addr[31 -: TAG_W];
  assign w_unused = ^req_addr[OFFSET_W-1:0];
  assign w_idle = r_state == ST_IDLE;
  assign w_refill = r_state == ST_REFILL;
  // descending scan so the lowest-numbered match / invalid way wins
  always_comb begin
    w_match = '0;
    w_hit_way = '0;
    w_free = 1'b0;
    w_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_match[w] = r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag;
      if (w_match[w]) w_hit_way = WAY_W'(w);
      if (!r_valid[w_idx][w]) begin
        w_free = 1'b1;
        w_free_way = WAY_W'(w);
      end
    end
  end
  // the PLRU port serves the refill set while filling, the lookup set otherwise
  assign w_set = w_refill ? r_idx : w_idx;
  plru_tree #(.WAYS(WAYS)) u_plru (
    .i_bits  (r_plru[w_set]),
    .i_way   (w_refill ? r_victim : w_hit_way),
    .o_victim(w_plru_victim),
    .o_next  (w_plru_next)
  );
  assign w_victim = w_free ? w_free_way : w_plru_victim;
  assign w_lookup = cached & req_en & ~flush & w_idle & ~rst;
  assign hit = w_lookup ? w_match : '0;
  assign miss = w_lookup & ~|w_match & ~cop_valid;
  assign w_cop_idx_op = cop_type == COP_INDEX_INV || cop_type == COP_INDEX_STORE_TAG || cop_type == COP_INDEX_WB_INV;
  assign w_cop_hit_op = cop_type == COP_HIT_INV || cop_type == COP_HIT_WB_INV;
  // index ops take the way from the low tag bits; hit ops use the tag match alone
  assign w_cop_way = w_cop_idx_op ? req_addr[OFFSET_W + IDX_W +: WAY_W] : w_hit_way;
  assign w_cop_sel = w_cop_idx_op | (w_cop_hit_op & |w_match);
  assign w_cop_wb = (cop_type == COP_INDEX_WB_INV || cop_type == COP_HIT_WB_INV) & w_cop_sel & r_valid[w_idx][w_cop_way] & r_dirty[w_idx][w_cop_way];
  assign w_cop_go = cop_valid & w_idle & ~rst;
  assign cop_done = (w_cop_go & ~w_cop_wb) | (r_state == ST_COP_WB & wb_ack & ~rst);
  assign stallreq = ~rst & (miss | ~w_idle | (cop_valid & ~cop_done));
  assign wb_req = ~rst & (r_state == ST_WB || r_state == ST_COP_WB);
  assign wb_addr = wb_req ? {r_tag[r_idx][r_victim], r_idx, OFFSET_W'(0)} : '0;
  assign rf_req = ~rst & w_refill;
  assign rf_addr = rf_req ? {r_tag_l, r_idx, OFFSET_W'(0)} : '0;
  assign victim = (w_idle | rst) ? '0 : r_victim;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_victim <= '0;
      r_tag_l <= '0;
      r_idx <= '0;
      r_we <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_tag[s][w] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE:
          if (cop_valid) begin
            if (w_cop_wb) begin
              r_state <= ST_COP_WB;
              r_idx <= w_idx;
              r_victim <= w_cop_way;
            end else if (w_cop_sel) begin
              r_valid[w_idx][w_cop_way] <= 1'b0;
              r_dirty[w_idx][w_cop_way] <= 1'b0;
              r_tag[w_idx][w_cop_way] <= '0;
            end
          end else if (miss) begin
            r_victim <= w_victim;
            r_tag_l <= w_tag;
            r_idx <= w_idx;
            r_we <= req_we;
            r_state <= (r_valid[w_idx][w_victim] & r_dirty[w_idx][w_victim]) ? ST_WB : ST_REFILL;
          end else if (|hit) begin
            r_plru[w_idx] <= w_plru_next;
            if (req_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
          end
        ST_WB:
          if (wb_ack) r_state <= ST_REFILL;
        ST_REFILL:
          if (rf_ack) begin
            r_tag[r_idx][r_victim] <= r_tag_l;
            r_valid[r_idx][r_victim] <= 1'b1;
            r_dirty[r_idx][r_victim] <= r_we;
            r_plru[r_idx] <= w_plru_next;
            r_state <= ST_IDLE;
          end
        default:
          if (wb_ack) begin
            r_valid[r_idx][r_victim] <= 1'b0;
            r_dirty[r_idx][r_victim] <= 1'b0;
            r_tag[r_idx][r_victim] <= '0;
            r_state <= ST_IDLE;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_tag_nway.sv
// tb_cache_tag_nway: directed vectors plus randomized checking of 2-way and 4-way tag stores
module tb_cache_tag_nway;
  logic clk, rst, flush, cached, req_en, req_we, wb_ack, rf_ack, cop_valid;
  logic [31:0] req_addr;
  logic [2:0] cop_type;
  logic [1:0] hit2;
  logic [3:0] hit4;
  logic miss2, stall2, wbq2, rfq2, cd2, miss4, stall4, wbq4, rfq4, cd4;
  logic [0:0] vic2;
  logic [1:0] vic4;
  logic [31:0] wba2, rfa2, wba4, rfa4;
  int checks = 0, errors = 0;

  cache_tag_nway #(.WAYS(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .cached(cached), .req_en(req_en), .req_we(req_we),
    .req_addr(req_addr), .hit(hit2), .miss(miss2), .stallreq(stall2), .victim(vic2),
    .wb_req(wbq2), .wb_addr(wba2), .wb_ack(wb_ack), .rf_req(rfq2), .rf_addr(rfa2), .rf_ack(rf_ack),
    .cop_valid(cop_valid), .cop_type(cop_type), .cop_done(cd2)
  );
  cache_tag_nway #(.WAYS(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .cached(cached), .req_en(req_en), .req_we(req_we),
    .req_addr(req_addr), .hit(hit4), .miss(miss4), .stallreq(stall4), .victim(vic4),
    .wb_req(wbq4), .wb_addr(wba4), .wb_ack(wb_ack), .rf_req(rfq4), .rf_addr(rfa4), .rf_ack(rf_ack),
    .cop_valid(cop_valid), .cop_type(cop_type), .cop_done(cd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] a;
    logic en, c, fl, we, ra;
    logic [1:0] hit;
    logic miss, stall, rf;
    logic [31:0] rfa;
  } vec_t;
  vec_t tv [12];

  // reference model: per-instance line contents, PLRU pointers and pending transaction
  bit mv [2][64][4];
  bit md [2][64][4];
  logic [19:0] mt [2][64][4];
  bit pr [2][64];
  bit pl [2][64];
  bit prr [2][64];
  int mmode [2];
  int mway [2];
  int midx [2];
  logic [19:0] mtag [2];
  bit mwe [2];

  task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [72:0] o2();
    return {2'b00, hit2, miss2, stall2, wbq2, wba2, rfq2, rfa2, cd2};
  endfunction

  function automatic logic [72:0] o4();
    return {hit4, miss4, stall4, wbq4, wba4, rfq4, rfa4, cd4};
  endfunction

  task automatic idle_inputs();
    flush = 0; cached = 1; req_en = 0; req_we = 0; req_addr = '0;
    wb_ack = 0; rf_ack = 0; cop_valid = 0; cop_type = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset_out2", o2(), '0);
    chk("reset_out4", o4(), '0);
    for (int k = 0; k < 2; k++) begin
      mmode[k] = 0; mway[k] = 0; midx[k] = 0; mtag[k] = '0; mwe[k] = 0;
      for (int s = 0; s < 64; s++) begin
        pr[k][s] = 0; pl[k][s] = 0; prr[k][s] = 0;
        for (int w = 0; w < 4; w++) begin
          mv[k][s][w] = 0; md[k][s][w] = 0; mt[k][s][w] = '0;
        end
      end
    end
  endtask

  task automatic step(input logic [31:0] a = '0, input logic en = 0, input logic we = 0,
                      input logic fl = 0, input logic ra = 0, input logic wa = 0,
                      input logic cv = 0, input logic [2:0] ct = '0, input logic c = 1);
    @(negedge clk);
    req_addr = a; req_en = en; req_we = we; flush = fl; rf_ack = ra; wb_ack = wa;
    cop_valid = cv; cop_type = ct; cached = c;
    #1;
  endtask

  function automatic int pvictim(input int k, input int s);
    if (k == 0) return pr[k][s] ? 1 : 0;
    return pr[k][s] ? (prr[k][s] ? 3 : 2) : (pl[k][s] ? 1 : 0);
  endfunction

  // accessing way w makes every level point toward the other half / sibling
  task automatic touch(input int k, input int s, input int w);
    if (k == 0) pr[k][s] = (w == 0);
    else begin
      pr[k][s] = (w < 2);
      if (w < 2) pl[k][s] = (w == 0);
      else prr[k][s] = (w == 2);
    end
  endtask

  task automatic model(input int k, output logic [72:0] e);
    int ways, idx, hw, cw, vw;
    logic [19:0] tg;
    logic found, idle, look, emiss, cdone, sel, wbv, idxop, hitop, ewb, erf;
    logic [3:0] eh;
    logic [31:0] ewa, era;
    ways = k ? 4 : 2;
    idx = int'(req_addr[11:6]);
    tg = req_addr[31:12];
    found = 0; hw = 0;
    for (int i = ways - 1; i >= 0; i--)
      if (mv[k][idx][i] && mt[k][idx][i] == tg) begin found = 1; hw = i; end
    idle = mmode[k] == 0;
    look = cached && req_en && !flush && idle;
    eh = (look && found) ? 4'(1 << hw) : 4'd0;
    emiss = look && !found && !cop_valid;
    idxop = cop_type == 0 || cop_type == 1 || cop_type == 3;
    hitop = cop_type == 2 || cop_type == 4;
    cw = idxop ? int'(tg) % ways : hw;
    sel = idxop || (hitop && found);
    wbv = (cop_type == 3 || cop_type == 4) && sel && mv[k][idx][cw] && md[k][idx][cw];
    cdone = (idle && cop_valid && !wbv) || (mmode[k] == 3 && wb_ack);
    ewb = mmode[k] == 1 || mmode[k] == 3;
    erf = mmode[k] == 2;
    ewa = ewb ? {mt[k][midx[k]][mway[k]], 6'(midx[k]), 6'd0} : 32'd0;
    era = erf ? {mtag[k], 6'(midx[k]), 6'd0} : 32'd0;
    e = {eh, emiss, emiss || !idle || (cop_valid && !cdone), ewb, ewa, erf, era, cdone};
    case (mmode[k])
      0:
        if (cop_valid) begin
          if (wbv) begin mmode[k] = 3; midx[k] = idx; mway[k] = cw; end
          else if (sel) begin mv[k][idx][cw] = 0; md[k][idx][cw] = 0; mt[k][idx][cw] = '0; end
        end else if (emiss) begin
          vw = -1;
          for (int i = ways - 1; i >= 0; i--) if (!mv[k][idx][i]) vw = i;
          if (vw < 0) vw = pvictim(k, idx);
          mway[k] = vw; midx[k] = idx; mtag[k] = tg; mwe[k] = req_we;
          mmode[k] = (mv[k][idx][vw] && md[k][idx][vw]) ? 1 : 2;
        end else if (eh != 0) begin
          touch(k, idx, hw);
          if (req_we) md[k][idx][hw] = 1;
        end
      1: if (wb_ack) mmode[k] = 2;
      2:
        if (rf_ack) begin
          mv[k][midx[k]][mway[k]] = 1;
          md[k][midx[k]][mway[k]] = mwe[k];
          mt[k][midx[k]][mway[k]] = mtag[k];
          touch(k, midx[k], mway[k]);
          mmode[k] = 0;
        end
      default:
        if (wb_ack) begin
          mv[k][midx[k]][mway[k]] = 0; md[k][midx[k]][mway[k]] = 0; mt[k][midx[k]][mway[k]] = '0;
          mmode[k] = 0;
        end
    endcase
  endtask

  initial begin
    logic [72:0] e;
    logic [31:0] a4;
    // a, en, c, fl, we, ra, hit, miss, stall, rf_req, rf_addr
    tv[0]  = '{32'h1000_0040, 1, 1, 0, 0, 0, 2'b00, 1, 1, 0, 32'h0};
    tv[1]  = '{32'h0,         0, 1, 0, 0, 0, 2'b00, 0, 1, 1, 32'h1000_0040};
    tv[2]  = '{32'h0,         0, 1, 0, 0, 1, 2'b00, 0, 1, 1, 32'h1000_0040};
    tv[3]  = '{32'h1000_0040, 1, 1, 0, 0, 0, 2'b01, 0, 0, 0, 32'h0};
    tv[4]  = '{32'h3000_0040, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0};
    tv[5]  = '{32'h3000_0040, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0, 32'h0};
    tv[6]  = '{32'h1000_0040, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 32'h0};
    tv[7]  = '{32'h1000_0040, 1, 1, 0, 1, 0, 2'b01, 0, 0, 0, 32'h0};
    tv[8]  = '{32'h3000_0040, 1, 1, 0, 0, 0, 2'b00, 1, 1, 0, 32'h0};
    tv[9]  = '{32'h0,         0, 1, 0, 0, 0, 2'b00, 0, 1, 1, 32'h3000_0040};
    tv[10] = '{32'h0,         0, 1, 0, 0, 1, 2'b00, 0, 1, 1, 32'h3000_0040};
    tv[11] = '{32'h3000_0040, 1, 1, 0, 0, 0, 2'b10, 0, 0, 0, 32'h0};
    rst = 1;
    idle_inputs();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tv[i].a, tv[i].en, tv[i].we, tv[i].fl, tv[i].ra, 0, 0, 3'd0, tv[i].c);
      chk($sformatf("vec%0d", i), {hit2, miss2, stall2, rfq2, rfa2, wbq2},
          {tv[i].hit, tv[i].miss, tv[i].stall, tv[i].rf, tv[i].rfa, 1'b0});
    end

    // dirty victim write-back with a delayed ack, then a flushed refill
    step(32'h2000_0000, 1, 1);            chk("st_miss", miss2, 1);
    step('0, 0, 0, 0, 1);
    step(32'h2000_0000, 1, 1);            chk("st_hit", hit2, 2'b01);
    step(32'h3000_0000, 1);               chk("fill1_miss", miss2, 1);
    step('0, 0, 0, 0, 1);
    step(32'h4000_0000, 1);               chk("conflict_miss", miss2, 1);
    step();                               chk("wb_start", {wbq2, wba2, vic2, rfq2}, {1'b1, 32'h2000_0000, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("wb_hold%0d", i), {stall2, wbq2, rfq2}, 3'b110);
    end
    step('0, 0, 0, 0, 0, 1);              chk("wb_ack_cycle", {wbq2, stall2}, 2'b11);
    step();                               chk("after_wb", {rfq2, rfa2, wbq2}, {1'b1, 32'h4000_0000, 1'b0});
    step(32'h4000_0000, 1, 0, 1, 1);      chk("flush_refill", {rfq2, hit2, miss2}, {1'b1, 2'b00, 1'b0});
    step(32'h4000_0000, 1);               chk("installed", {hit2, stall2}, {2'b01, 1'b0});

    // reset while a write-back is pending
    step(32'h3000_0000, 1, 1);            chk("st_hit_w1", hit2, 2'b10);
    step(32'h4000_0000, 1);               chk("ld_hit_w0", hit2, 2'b01);
    step(32'h5000_0000, 1);               chk("miss_to_wb", miss2, 1);
    step();                               chk("wb_w1", {wbq2, wba2}, {1'b1, 32'h3000_0000});
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_in_wb", o2(), '0);
    step(32'h4000_0000, 1);               chk("rst_invalidates", {miss2, hit2}, {1'b1, 2'b00});

    // cache ops on dirty lines
    do_reset();
    step(32'h2000_0000, 1, 1);            chk("cop_fill_miss", miss2, 1);
    step('0, 0, 0, 0, 1);
    step(32'h2000_0000, 1, 0, 0, 0, 0, 1, 3'd4);
    chk("hwbi_accept", {cd2, stall2, miss2}, 3'b010);
    step(32'h2000_0000, 0, 0, 0, 0, 0, 1, 3'd4);
    chk("hwbi_wb", {wbq2, wba2, cd2, stall2}, {1'b1, 32'h2000_0000, 1'b0, 1'b1});
    step(32'h2000_0000, 0, 0, 0, 0, 1, 1, 3'd4);
    chk("hwbi_done", {cd2, wbq2}, 2'b11);
    step(32'h2000_0000, 1, 1);            chk("hwbi_cleared", {miss2, cd2, wbq2}, 3'b100);
    step('0, 0, 0, 0, 1);
    step(32'h2000_0000, 1, 0, 0, 0, 0, 1, 3'd0);
    chk("iinv_one_cycle", {cd2, stall2, wbq2}, 3'b100);
    step(32'h2000_0000, 1);               chk("iinv_cleared", {miss2, wbq2, cd2}, 3'b100);

    // 4-way tree PLRU: fill set 1, touch ways 0 and 2, fifth tag replaces way 1
    do_reset();
    for (int t = 0; t < 4; t++) begin
      a4 = {20'h00100 + 20'(t), 6'd1, 6'd0};
      step(a4, 1);                        chk($sformatf("p4_miss%0d", t), miss4, 1);
      step('0, 0, 0, 0, 1);               chk($sformatf("p4_rf%0d", t), {rfq4, rfa4, vic4}, {1'b1, a4, 2'(t)});
    end
    step(32'h0010_0040, 1);               chk("p4_hit0", hit4, 4'b0001);
    step(32'h0010_2040, 1);               chk("p4_hit2", hit4, 4'b0100);
    step(32'h0010_4040, 1);               chk("p4_miss5", miss4, 1);
    step();                               chk("p4_victim", {vic4, rfq4, rfa4, wbq4}, {2'd1, 1'b1, 32'h0010_4040, 1'b0});
    step('0, 0, 0, 0, 1);
    step(32'h0010_4040, 1);               chk("p4_new_hit", hit4, 4'b0010);

    // randomized traffic on both instances against the reference model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      req_addr = {20'($urandom_range(0, 5)), 6'($urandom_range(0, 1)), 6'($urandom)};
      req_en = $urandom_range(0, 3) != 0;
      cached = $urandom_range(0, 7) != 0;
      req_we = $urandom_range(0, 1) != 0;
      flush = $urandom_range(0, 7) == 0;
      wb_ack = $urandom_range(0, 2) == 0;
      rf_ack = $urandom_range(0, 2) == 0;
      cop_valid = $urandom_range(0, 15) == 0;
      cop_type = 3'($urandom_range(0, 4));
      #1;
      model(0, e);
      chk($sformatf("rand2_%0d", n), o2(), e);
      model(1, e);
      chk($sformatf("rand4_%0d", n), o4(), e);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
